// File: rtl/reg_mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage: default field widths and
// the control-bundle field ordering shared by the EX/MEM and MEM/WB stages.
package reg_mem_wb_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_REG_W  = 4;

    // Write-back control bundle, MSB first. Both pipeline stages pack the
    // control bits through this type so the ordering can never diverge.
    typedef struct packed {
        logic sel_dat;
        logic sel_c;
        logic we_v;
        logic we_c;
        logic sel_sto;
    } memwb_ctrl_t;

    localparam int CTRL_W = $bits(memwb_ctrl_t);

    // Packs the individual control inputs into the shared bundle ordering.
    function automatic memwb_ctrl_t pack_ctrl(
        input logic sel_dat,
        input logic sel_c,
        input logic we_v,
        input logic we_c,
        input logic sel_sto
    );
        memwb_ctrl_t c;
        c.sel_dat = sel_dat;
        c.sel_c   = sel_c;
        c.we_v    = we_v;
        c.we_c    = we_c;
        c.sel_sto = sel_sto;
        return c;
    endfunction

endpackage

// File: rtl/reg_mem_wb_stage_pipe_reg_en.sv
// pipe_reg_en: parameterised flop vector with synchronous active-high reset
// and an active-high load enable. Reset takes priority over load.
module reg_mem_wb_stage_pipe_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state: take the new word when loading, otherwise recirculate.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    // State register with synchronous reset dominating the load path.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_mem_wb_stage.sv
// MEM/WB pipeline register of the image-filter processor. All fields are
// concatenated into one bundle and captured by a single enable/reset flop
// vector, so no field can ever update independently of the others.
module reg_mem_wb_stage
    import reg_mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic              SEL_DAT_In,
    input  logic              SEL_C_In,
    input  logic              WE_V_In,
    input  logic              WE_C_In,
    input  logic              SEL_STO_In,
    input  logic [DATA_W-1:0] Do_In,
    input  logic [BYTE_W-1:0] Dob_In,
    input  logic [DATA_W-1:0] ALU_Result_In,
    input  logic [REG_W-1:0]  Rg_In,
    output logic [DATA_W-1:0] Do,
    output logic [BYTE_W-1:0] Dob,
    output logic [DATA_W-1:0] ALU_Result,
    output logic              WE_C,
    output logic              WE_V,
    output logic              SEL_C,
    output logic              SEL_DAT,
    output logic              SEL_STO,
    output logic [REG_W-1:0]  Rg
);

    localparam int BUNDLE_W = 2 * DATA_W + BYTE_W + REG_W + CTRL_W;

    memwb_ctrl_t         ctrl_in_s;
    memwb_ctrl_t         ctrl_out_s;
    logic [BUNDLE_W-1:0] bundle_d;
    logic [BUNDLE_W-1:0] bundle_q;
    logic                load_s;

    // WE is active-low: 0 loads, 1 holds.
    assign load_s    = ~WE;
    assign ctrl_in_s = pack_ctrl(SEL_DAT_In, SEL_C_In, WE_V_In, WE_C_In, SEL_STO_In);
    assign bundle_d  = {Do_In, Dob_In, ALU_Result_In, Rg_In, ctrl_in_s};

    reg_mem_wb_stage_pipe_reg_en #(
        .W (BUNDLE_W)
    ) u_bundle_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_s),
        .d_i    (bundle_d),
        .q_o    (bundle_q)
    );

    // Outputs come straight from the flop vector; no input reaches them
    // without passing through a clock edge.
    assign {Do, Dob, ALU_Result, Rg, ctrl_out_s} = bundle_q;
    assign SEL_DAT = ctrl_out_s.sel_dat;
    assign SEL_C   = ctrl_out_s.sel_c;
    assign WE_V    = ctrl_out_s.we_v;
    assign WE_C    = ctrl_out_s.we_c;
    assign SEL_STO = ctrl_out_s.sel_sto;

endmodule

// File: tb/tb_reg_mem_wb_stage.sv
// Self-checking bench for reg_mem_wb_stage: directed reset/load/hold/isolation
// scenarios followed by randomized traffic against a field-level model.
module tb_reg_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        WE;
    logic        SEL_DAT_In, SEL_C_In, WE_V_In, WE_C_In, SEL_STO_In;
    logic [31:0] Do_In;
    logic [7:0]  Dob_In;
    logic [31:0] ALU_Result_In;
    logic [3:0]  Rg_In;
    logic [31:0] Do;
    logic [7:0]  Dob;
    logic [31:0] ALU_Result;
    logic        WE_C, WE_V, SEL_C, SEL_DAT, SEL_STO;
    logic [3:0]  Rg;

    // Reference model: what the write-back stage should currently see.
    logic [31:0] exp_do, exp_alu;
    logic [7:0]  exp_dob;
    logic [3:0]  exp_rg;
    logic        exp_we_c, exp_we_v, exp_sel_c, exp_sel_dat, exp_sel_sto;

    int n_checks = 0;
    int n_pass   = 0;

    reg_mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .WE            (WE),
        .SEL_DAT_In    (SEL_DAT_In),
        .SEL_C_In      (SEL_C_In),
        .WE_V_In       (WE_V_In),
        .WE_C_In       (WE_C_In),
        .SEL_STO_In    (SEL_STO_In),
        .Do_In         (Do_In),
        .Dob_In        (Dob_In),
        .ALU_Result_In (ALU_Result_In),
        .Rg_In         (Rg_In),
        .Do            (Do),
        .Dob           (Dob),
        .ALU_Result    (ALU_Result),
        .WE_C          (WE_C),
        .WE_V          (WE_V),
        .SEL_C         (SEL_C),
        .SEL_DAT       (SEL_DAT),
        .SEL_STO       (SEL_STO),
        .Rg            (Rg)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".Do"},         64'(Do),         64'(exp_do));
        check_val({tag, ".Dob"},        64'(Dob),        64'(exp_dob));
        check_val({tag, ".ALU_Result"}, 64'(ALU_Result), 64'(exp_alu));
        check_val({tag, ".Rg"},         64'(Rg),         64'(exp_rg));
        check_val({tag, ".WE_C"},       64'(WE_C),       64'(exp_we_c));
        check_val({tag, ".WE_V"},       64'(WE_V),       64'(exp_we_v));
        check_val({tag, ".SEL_C"},      64'(SEL_C),      64'(exp_sel_c));
        check_val({tag, ".SEL_DAT"},    64'(SEL_DAT),    64'(exp_sel_dat));
        check_val({tag, ".SEL_STO"},    64'(SEL_STO),    64'(exp_sel_sto));
    endtask

    task automatic set_inputs(input logic [4:0] ctrl, input logic [31:0] d,
                              input logic [7:0] b, input logic [31:0] a, input logic [3:0] r);
        {SEL_DAT_In, SEL_C_In, WE_V_In, WE_C_In, SEL_STO_In} = ctrl;
        Do_In = d; Dob_In = b; ALU_Result_In = a; Rg_In = r;
    endtask

    task automatic rand_inputs();
        set_inputs(5'($urandom), $urandom, 8'($urandom), $urandom, 4'($urandom));
    endtask

    // Apply the stage rules to the inputs present at the coming edge, take the
    // edge, then compare a little after it.
    task automatic tick(input string tag);
        if (rst) begin
            exp_do = 32'd0; exp_dob = 8'd0; exp_alu = 32'd0; exp_rg = 4'd0;
            exp_we_c = 1'b0; exp_we_v = 1'b0; exp_sel_c = 1'b0;
            exp_sel_dat = 1'b0; exp_sel_sto = 1'b0;
        end else if (WE == 1'b0) begin
            exp_do = Do_In; exp_dob = Dob_In; exp_alu = ALU_Result_In; exp_rg = Rg_In;
            exp_we_c = WE_C_In; exp_we_v = WE_V_In; exp_sel_c = SEL_C_In;
            exp_sel_dat = SEL_DAT_In; exp_sel_sto = SEL_STO_In;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset with nonzero inputs, both WE values.
        set_inputs(5'b11111, 32'hFFFF_FFFF, 8'hFF, 32'hA5A5_A5A5, 4'hF);
        rst = 1'b1; WE = 1'b0;
        tick("rst_we0");
        WE = 1'b1;
        tick("rst_we1");

        // Load test 1, and confirm nothing shows before the edge.
        rst = 1'b0; WE = 1'b0;
        set_inputs(5'b10101, 32'h0EAB_3321, 8'h12, 32'hEEEE_EEEE, 4'd5);
        #1;
        check_all("load1_pre_edge");
        tick("load1");

        // Hold for three edges while the inputs churn.
        WE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick("hold");
        end

        // Release the hold with the load-test-2 values.
        WE = 1'b0;
        set_inputs(5'b11111, 32'h0111_1111, 8'h11, 32'h2222_2222, 4'd3);
        tick("load2");

        // Mid-cycle input changes, first with clk high, then with clk low.
        rand_inputs();
        #1;
        check_all("comb_clk_high");
        @(negedge clk);
        #1;
        rand_inputs();
        #1;
        check_all("comb_clk_low");

        // Reset mid-stream over a load request, then resume loading.
        set_inputs(5'b11111, 32'h0111_1111, 8'h11, 32'h2222_2222, 4'd3);
        tick("load2_again");
        rst = 1'b1; WE = 1'b0;
        rand_inputs();
        tick("rst_mid");
        rst = 1'b0;
        rand_inputs();
        tick("rst_release");

        // Randomized traffic: occasional reset, mixed load/hold.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            WE  = 1'($urandom);
            rand_inputs();
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
